// File: rtl/half_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : half_arb_pkg
// Description : Shared types, constants and round-robin pick function for the
//               half_mult_arbiter block.
// Revision    : 1.0 - initial release
// ============================================================================
package half_arb_pkg;

    localparam int HALF_W   = 16;
    localparam int MAX_REQ  = 8;
    localparam int TAG_ID_W = 3;   // wide enough for MAX_REQ requesters

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // One-hot grant: first set bit of req at or after ptr, wrapping modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0]  req,
        input logic [TAG_ID_W-1:0] ptr,
        input int                  n
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int                 idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % n;
            if ((k < n) && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage
`default_nettype wire

// File: rtl/half_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : half_arb_if
// Description : Requester/response bundle between the layer sequencers and
//               the shared fp16 multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface half_arb_if
    import half_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*HALF_W-1:0] req_a;
    logic [NUM_REQ*HALF_W-1:0] req_b;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [HALF_W-1:0]         rsp_c;
    logic                      busy;
    logic                      tag_err;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_c, busy, tag_err
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_c, busy, tag_err
    );
endinterface
`default_nettype wire

// File: rtl/half_arb_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : half_arb_tag_pipe
// Description : {valid,id} delay line that tracks operations through the
//               multiplier pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module half_arb_tag_pipe
    import half_arb_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire tag_t i_d,
    output tag_t      o_q,
    output logic      o_any_valid
);
    tag_t r_stage [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) r_stage[gi] <= '0;
                    else     r_stage[gi] <= i_d;
                end
            end else begin : g_body
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) r_stage[gi] <= '0;
                    else     r_stage[gi] <= r_stage[gi-1];
                end
            end
        end
    endgenerate

    always_comb begin
        o_any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            o_any_valid = o_any_valid | r_stage[i].valid;
    end

    assign o_q = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/half_multiply.sv
`default_nettype none
// ============================================================================
// Module      : half_multiply
// Description : Two-stage pipelined fp16 multiplier, round-to-nearest-even.
//               Subnormal inputs and results flush to signed zero; NaN output
//               is the canonical quiet NaN 0x7E00.
// Revision    : 1.0 - initial release
// ============================================================================
module half_multiply
    import half_arb_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rstn,
    input  wire logic              in_valid,
    input  wire logic [HALF_W-1:0] a,
    input  wire logic [HALF_W-1:0] b,
    output logic                   out_valid,
    output logic [HALF_W-1:0]      c
);
    localparam logic [1:0] c_cls_num  = 2'd0;
    localparam logic [1:0] c_cls_zero = 2'd1;
    localparam logic [1:0] c_cls_inf  = 2'd2;
    localparam logic [1:0] c_cls_nan  = 2'd3;

    logic        w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
    logic [1:0]  w_cls;
    logic [21:0] w_prod;

    logic        r_s1_valid, r_s1_sign;
    logic [1:0]  r_s1_cls;
    logic [6:0]  r_s1_exp;
    logic [21:0] r_s1_prod;

    always_comb begin
        w_a_zero = (a[14:10] == 5'd0);
        w_b_zero = (b[14:10] == 5'd0);
        w_a_inf  = (&a[14:10]) && (a[9:0] == 10'd0);
        w_b_inf  = (&b[14:10]) && (b[9:0] == 10'd0);
        w_a_nan  = (&a[14:10]) && (a[9:0] != 10'd0);
        w_b_nan  = (&b[14:10]) && (b[9:0] != 10'd0);
        w_prod   = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
            w_cls = c_cls_nan;
        else if (w_a_inf || w_b_inf)
            w_cls = c_cls_inf;
        else if (w_a_zero || w_b_zero)
            w_cls = c_cls_zero;
        else
            w_cls = c_cls_num;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_cls   <= c_cls_zero;
            r_s1_exp   <= '0;
            r_s1_prod  <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= a[15] ^ b[15];
                r_s1_cls  <= w_cls;
                r_s1_exp  <= {2'b00, a[14:10]} + {2'b00, b[14:10]};
                r_s1_prod <= w_prod;
            end
        end
    end

    logic        w_norm, w_guard, w_sticky;
    logic [9:0]  w_mant;
    logic [10:0] w_round;
    logic [7:0]  w_exp;
    logic [15:0] w_res;

    always_comb begin
        // Product of two 1.x significands lies in [1,4); bit 21 marks [2,4).
        w_norm   = r_s1_prod[21];
        w_mant   = w_norm ? r_s1_prod[20:11] : r_s1_prod[19:10];
        w_guard  = w_norm ? r_s1_prod[10]    : r_s1_prod[9];
        w_sticky = w_norm ? (|r_s1_prod[9:0]) : (|r_s1_prod[8:0]);
        w_round  = {1'b0, w_mant} + {10'd0, w_guard & (w_sticky | w_mant[0])};
        w_exp    = {1'b0, r_s1_exp} + {7'd0, w_norm} + {7'd0, w_round[10]};
        w_res    = {r_s1_sign, 15'd0};
        case (r_s1_cls)
            c_cls_nan:  w_res = 16'h7E00;
            c_cls_inf:  w_res = {r_s1_sign, 5'h1F, 10'd0};
            c_cls_zero: w_res = {r_s1_sign, 15'd0};
            default: begin
                if (w_exp >= 8'd46)
                    w_res = {r_s1_sign, 5'h1F, 10'd0};
                else if (w_exp <= 8'd15)
                    w_res = {r_s1_sign, 15'd0};
                else
                    w_res = {r_s1_sign, 5'(w_exp - 8'd15), w_round[9:0]};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            c         <= '0;
        end else begin
            out_valid <= r_s1_valid;
            if (r_s1_valid)
                c <= w_res;
        end
    end

endmodule
`default_nettype wire

// File: rtl/half_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : half_mult_arbiter
// Description : Round-robin sharing of one pipelined half_multiply among
//               NUM_REQ requesters; products are routed back by ID tag.
//               Optional macro HALF_ARB_TAG_CHECK_EN enables tag_err.
// Revision    : 1.0 - initial release
// ============================================================================
module half_mult_arbiter
    import half_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MULT_LATENCY = 2,
    parameter int ID_W         = $clog2(NUM_REQ)
)
(
    input  wire logic clk,
    input  wire logic rst,
    half_arb_if.slave bus
);
    logic                r_run;
    logic [ID_W-1:0]     r_ptr;
    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_gid;
    logic [HALF_W-1:0]   w_sel_a, w_sel_b;
    logic                w_xfer;

    logic                r_iss_valid;
    logic [ID_W-1:0]     r_iss_id;
    logic [HALF_W-1:0]   r_iss_a, r_iss_b;

    tag_t                w_iss_tag, w_tail;
    logic                w_pipe_busy;
    logic                w_mult_valid;
    logic [HALF_W-1:0]   w_mult_c;
    logic [ID_W-1:0]     w_tail_id;

    // Grants are withheld for one cycle after reset so every output reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_run <= 1'b0;
        else     r_run <= 1'b1;
    end

    always_comb begin
        w_grant = r_run ? NUM_REQ'(rr_pick(MAX_REQ'(bus.req_valid), TAG_ID_W'(r_ptr), NUM_REQ))
                        : '0;
        w_gid   = '0;
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gid   = ID_W'(i);
                w_sel_a = bus.req_a[HALF_W*i +: HALF_W];
                w_sel_b = bus.req_b[HALF_W*i +: HALF_W];
            end
        end
        w_xfer = |(w_grant & bus.req_valid);
    end

    assign bus.req_ready = w_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_gid == ID_W'(NUM_REQ-1)) ? '0 : w_gid + ID_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iss_valid <= 1'b0;
            r_iss_id    <= '0;
            r_iss_a     <= '0;
            r_iss_b     <= '0;
        end else begin
            r_iss_valid <= w_xfer;
            if (w_xfer) begin
                r_iss_id <= w_gid;
                r_iss_a  <= w_sel_a;
                r_iss_b  <= w_sel_b;
            end
        end
    end

    assign w_iss_tag = '{valid: r_iss_valid, id: TAG_ID_W'(r_iss_id)};

    half_arb_tag_pipe #(
        .DEPTH (MULT_LATENCY)
    ) u_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .i_d         (w_iss_tag),
        .o_q         (w_tail),
        .o_any_valid (w_pipe_busy)
    );

    half_multiply u_mult (
        .clk       (clk),
        .rstn      (~rst),
        .in_valid  (r_iss_valid),
        .a         (r_iss_a),
        .b         (r_iss_b),
        .out_valid (w_mult_valid),
        .c         (w_mult_c)
    );

    assign w_tail_id     = ID_W'(w_tail.id);
    assign bus.rsp_valid = w_mult_valid ? (NUM_REQ'(1) << w_tail_id) : '0;
    assign bus.rsp_id    = w_tail_id;
    assign bus.rsp_c     = w_mult_c;
    assign bus.busy      = r_iss_valid | w_pipe_busy;

`ifdef HALF_ARB_TAG_CHECK_EN
    logic r_tag_err;

    // A disagreement means MULT_LATENCY does not match the real multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tag_err <= 1'b0;
        else if (w_mult_valid != w_tail.valid)
            r_tag_err <= 1'b1;
    end

    assign bus.tag_err = r_tag_err;
`else
    assign bus.tag_err = 1'b0;
`endif

endmodule
`default_nettype wire
